cu_access_arbiter: RTL and testbench

- Shares the config unit's arbiter-side port between two requesters: IFU (instruction fetch) and DFU (data fetch).
- Serialises single-beat register reads and writes, and drives the ar2cu_* handshake.
- Defers new grants while an APB write is in progress (cu2ar_busy) or before the workload is started (cu2ar_start_wl).
- Returns read data, write completion and a timeout error to the owning requester.

---
 rtl/cu_arb_pkg.sv | 25 ++
 rtl/cu_access_arbiter_rr_arb2.sv | 36 +++
 rtl/cu_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cu_access_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_arb_pkg.sv
// Shared types and constants for the config-unit access arbiter:
// FSM state encoding, requester IDs and well-known config-unit register addresses.
package cu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_DFU = 1'b1
  } owner_e;

  localparam logic [31:0] ADDR_PROG_SIZE  = 32'h3fe;
  localparam logic [31:0] ADDR_PROG_START = 32'h400;
  localparam logic [31:0] ADDR_DMA_SIZE   = 32'h403;
  localparam logic [31:0] ADDR_DMA_SRC    = 32'h405;
  localparam logic [31:0] ADDR_DMA_DST    = 32'h407;
  localparam logic [31:0] ADDR_DFU_2      = 32'h411;
  localparam logic [31:0] ADDR_DFU_3      = 32'h413;

endpackage

// File: rtl/cu_access_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant vector, registered
// last-grant pointer that only moves when the owning transaction completes.
module rr_arb2
  import cu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       upd,
  input  owner_e     upd_owner,
  output logic [1:0] gnt
);

  owner_e last_q;

  // Pointer starts on DFU so that IFU wins the first contended round.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= OWN_DFU;
    end else if (upd) begin
      last_q <= upd_owner;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == OWN_DFU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cu_access_arbiter.sv
// Shares the config unit's arbiter-side port between IFU and DFU, serialising
// single-beat register reads/writes and returning data, completion and timeout errors.
module cu_access_arbiter
  import cu_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int CU_DATA_WIDTH = 64,
  parameter int RD_TIMEOUT    = 15,
  parameter int ERRCNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ifu_req,
  input  logic                     ifu_we,
  input  logic [ADDR_WIDTH-1:0]    ifu_addr,
  input  logic [CU_DATA_WIDTH-1:0] ifu_wdata,
  output logic                     ifu_gnt,
  output logic                     ifu_resp_valid,
  output logic [CU_DATA_WIDTH-1:0] ifu_rdata,
  output logic                     ifu_err,
  input  logic                     dfu_req,
  input  logic                     dfu_we,
  input  logic [ADDR_WIDTH-1:0]    dfu_addr,
  input  logic [CU_DATA_WIDTH-1:0] dfu_wdata,
  output logic                     dfu_gnt,
  output logic                     dfu_resp_valid,
  output logic [CU_DATA_WIDTH-1:0] dfu_rdata,
  output logic                     dfu_err,
  output logic [ADDR_WIDTH-1:0]    ar2cu_addr,
  output logic                     ar2cu_addr_valid,
  output logic                     ar2cu_wr_rqst,
  output logic                     ar2cu_rd_rqst,
  output logic [CU_DATA_WIDTH-1:0] ar2cu_data_in,
  output logic                     ar2cu_data_in_valid,
  input  logic [CU_DATA_WIDTH-1:0] cu2ar_data_out,
  input  logic                     cu2ar_data_out_valid,
  input  logic                     cu2ar_busy,
  input  logic                     cu2ar_start_wl,
  output logic [ERRCNT_WIDTH-1:0]  arb_err_cnt
);

  localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  arb_state_e               state_q, state_d;
  owner_e                   owner_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [CU_DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]         to_cnt_q;
  logic [ERRCNT_WIDTH-1:0]  err_cnt_q;
  logic [CU_DATA_WIDTH-1:0] ifu_rdata_q, dfu_rdata_q;
  logic                     ifu_err_q, dfu_err_q;

  logic                     grant_ok;
  logic [1:0]               req_vec, gnt_vec;
  owner_e                   win;
  logic                     sel_we;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [CU_DATA_WIDTH-1:0] sel_wdata;
  logic                     rd_timeout;
  logic                     res_load;
  logic [CU_DATA_WIDTH-1:0] res_data;
  logic                     res_err;

  // Grant is combinational in IDLE; gating with rstn keeps it low while reset is held.
  assign grant_ok = rstn && cu2ar_start_wl && !cu2ar_busy && (state_q == ST_IDLE);
  assign req_vec  = {dfu_req, ifu_req} & {2{grant_ok}};

  rr_arb2 u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_vec),
    .upd       (state_q == ST_RESP),
    .upd_owner (owner_q),
    .gnt       (gnt_vec)
  );

  assign win       = gnt_vec[1] ? OWN_DFU : OWN_IFU;
  assign sel_we    = gnt_vec[1] ? dfu_we    : ifu_we;
  assign sel_addr  = gnt_vec[1] ? dfu_addr  : ifu_addr;
  assign sel_wdata = gnt_vec[1] ? dfu_wdata : ifu_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|gnt_vec) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = we_q ? ST_RESP : ST_WAIT_RD;
      ST_WAIT_RD: if (cu2ar_data_out_valid || rd_timeout) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A valid arriving on the final wait cycle takes precedence over the timeout.
  always_comb begin
    res_load   = 1'b0;
    res_data   = '0;
    res_err    = 1'b0;
    rd_timeout = (state_q == ST_WAIT_RD) && !cu2ar_data_out_valid && (to_cnt_q == CNT_LAST);
    if (state_q == ST_ISSUE && we_q) begin
      res_load = 1'b1;
    end else if (state_q == ST_WAIT_RD && cu2ar_data_out_valid) begin
      res_load = 1'b1;
      res_data = cu2ar_data_out;
    end else if (rd_timeout) begin
      res_load = 1'b1;
      res_err  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q     <= OWN_IFU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      to_cnt_q    <= '0;
      err_cnt_q   <= '0;
      ifu_rdata_q <= '0;
      dfu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      dfu_err_q   <= 1'b0;
    end else begin
      if (|gnt_vec) begin
        owner_q <= win;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        // Write data only moves on writes so ar2cu_data_in keeps the last written value.
        if (sel_we) wdata_q <= sel_wdata;
      end
      if (state_q == ST_ISSUE) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_WAIT_RD) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (rd_timeout && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
      if (res_load) begin
        if (owner_q == OWN_IFU) begin
          ifu_rdata_q <= res_data;
          ifu_err_q   <= res_err;
        end else begin
          dfu_rdata_q <= res_data;
          dfu_err_q   <= res_err;
        end
      end
    end
  end

  assign ifu_gnt             = gnt_vec[0];
  assign dfu_gnt             = gnt_vec[1];
  assign ar2cu_addr          = addr_q;
  assign ar2cu_data_in       = wdata_q;
  assign ar2cu_addr_valid    = (state_q == ST_ISSUE);
  assign ar2cu_wr_rqst       = (state_q == ST_ISSUE) && we_q;
  assign ar2cu_rd_rqst       = (state_q == ST_ISSUE) && !we_q;
  assign ar2cu_data_in_valid = (state_q == ST_ISSUE) && we_q;
  assign ifu_resp_valid      = (state_q == ST_RESP) && (owner_q == OWN_IFU);
  assign dfu_resp_valid      = (state_q == ST_RESP) && (owner_q == OWN_DFU);
  assign ifu_rdata           = ifu_rdata_q;
  assign dfu_rdata           = dfu_rdata_q;
  assign ifu_err             = ifu_err_q;
  assign dfu_err             = dfu_err_q;
  assign arb_err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_cu_access_arbiter.sv
// Self-checking bench for cu_access_arbiter: transaction-age model compared every
// cycle, plus directed scenarios with hand-computed latencies and values.
module tb_cu_access_arbiter;
  import cu_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RT = 15;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ifu_req, ifu_we, dfu_req, dfu_we;
  logic [AW-1:0] ifu_addr, dfu_addr;
  logic [DW-1:0] ifu_wdata, dfu_wdata;
  logic          ifu_gnt, ifu_resp_valid, ifu_err;
  logic          dfu_gnt, dfu_resp_valid, dfu_err;
  logic [DW-1:0] ifu_rdata, dfu_rdata;
  logic [AW-1:0] ar2cu_addr;
  logic          ar2cu_addr_valid, ar2cu_wr_rqst, ar2cu_rd_rqst, ar2cu_data_in_valid;
  logic [DW-1:0] ar2cu_data_in, cu2ar_data_out;
  logic          cu2ar_data_out_valid, cu2ar_busy, cu2ar_start_wl;
  logic [EW-1:0] arb_err_cnt;

  cu_access_arbiter #(
    .ADDR_WIDTH(AW), .CU_DATA_WIDTH(DW), .RD_TIMEOUT(RT), .ERRCNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req(ifu_req), .ifu_we(ifu_we), .ifu_addr(ifu_addr), .ifu_wdata(ifu_wdata),
    .ifu_gnt(ifu_gnt), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .dfu_req(dfu_req), .dfu_we(dfu_we), .dfu_addr(dfu_addr), .dfu_wdata(dfu_wdata),
    .dfu_gnt(dfu_gnt), .dfu_resp_valid(dfu_resp_valid), .dfu_rdata(dfu_rdata), .dfu_err(dfu_err),
    .ar2cu_addr(ar2cu_addr), .ar2cu_addr_valid(ar2cu_addr_valid),
    .ar2cu_wr_rqst(ar2cu_wr_rqst), .ar2cu_rd_rqst(ar2cu_rd_rqst),
    .ar2cu_data_in(ar2cu_data_in), .ar2cu_data_in_valid(ar2cu_data_in_valid),
    .cu2ar_data_out(cu2ar_data_out), .cu2ar_data_out_valid(cu2ar_data_out_valid),
    .cu2ar_busy(cu2ar_busy), .cu2ar_start_wl(cu2ar_start_wl), .arb_err_cnt(arb_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Config-unit stub: answers a read one cycle after rd_rqst when enabled.
  bit   stub_on = 1'b0;
  logic stub_saw;
  initial begin
    cu2ar_data_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      stub_saw = ar2cu_rd_rqst;
      @(posedge clk);
      #1;
      cu2ar_data_out_valid = stub_saw && stub_on;
    end
  end

  // Model: a transaction is tracked by its age in cycles since grant.
  // Age 1 is the issue cycle; the response lands at age 2 for writes, one cycle
  // after read data (or after RT wait cycles) for reads.
  bit            m_act;
  int            m_age, m_resp_at, m_errcnt;
  logic          m_owner, m_we, m_last, m_res_err;
  logic [AW-1:0] m_iss_addr;
  logic [DW-1:0] m_iss_data, m_res_data;
  logic [DW-1:0] m_rd [2];
  logic          m_er [2];
  logic          e_ok, e_win, e_iss, e_rsp;

  task automatic model_reset();
    m_act = 1'b0; m_age = 0; m_resp_at = 0; m_errcnt = 0;
    m_owner = 1'b0; m_we = 1'b0; m_last = 1'b1; m_res_err = 1'b0;
    m_iss_addr = '0; m_iss_data = '0; m_res_data = '0;
    m_rd[0] = '0; m_rd[1] = '0; m_er[0] = 1'b0; m_er[1] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rstn) model_reset();
    e_ok  = rstn && !m_act && cu2ar_start_wl && !cu2ar_busy && (ifu_req || dfu_req);
    e_win = (ifu_req && dfu_req) ? !m_last : dfu_req;
    e_iss = m_act && (m_age == 1);
    e_rsp = m_act && (m_age == m_resp_at);
    check("ifu_gnt", 64'(ifu_gnt), 64'(e_ok && !e_win));
    check("dfu_gnt", 64'(dfu_gnt), 64'(e_ok && e_win));
    check("addr_valid", 64'(ar2cu_addr_valid), 64'(e_iss));
    check("wr_rqst", 64'(ar2cu_wr_rqst), 64'(e_iss && m_we));
    check("rd_rqst", 64'(ar2cu_rd_rqst), 64'(e_iss && !m_we));
    check("data_in_valid", 64'(ar2cu_data_in_valid), 64'(e_iss && m_we));
    check("ar2cu_addr", 64'(ar2cu_addr), 64'(m_iss_addr));
    check("ar2cu_data_in", ar2cu_data_in, m_iss_data);
    check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(e_rsp && !m_owner));
    check("dfu_resp_valid", 64'(dfu_resp_valid), 64'(e_rsp && m_owner));
    check("ifu_rdata", ifu_rdata, m_rd[0]);
    check("ifu_err", 64'(ifu_err), 64'(m_er[0]));
    check("dfu_rdata", dfu_rdata, m_rd[1]);
    check("dfu_err", 64'(dfu_err), 64'(m_er[1]));
    check("arb_err_cnt", 64'(arb_err_cnt), 64'(m_errcnt));
    if (rstn) begin
      if (!m_act) begin
        if (e_ok) begin
          m_act = 1'b1; m_age = 0; m_owner = e_win;
          m_we = e_win ? dfu_we : ifu_we;
          m_iss_addr = e_win ? dfu_addr : ifu_addr;
          if (m_we) begin
            m_iss_data = e_win ? dfu_wdata : ifu_wdata;
            m_resp_at = 2; m_res_data = '0; m_res_err = 1'b0;
          end else begin
            m_resp_at = 0;
          end
        end
      end else if (m_age == m_resp_at) begin
        m_act = 1'b0; m_last = m_owner;
      end else if (!m_we && m_age >= 2 && m_resp_at == 0) begin
        if (cu2ar_data_out_valid) begin
          m_res_data = cu2ar_data_out; m_res_err = 1'b0; m_resp_at = m_age + 1;
        end else if (m_age - 1 == RT) begin
          m_res_data = '0; m_res_err = 1'b1; m_resp_at = m_age + 1;
          if (m_errcnt < ERR_MAX) m_errcnt++;
        end
      end
      if (m_act) begin
        if (m_age + 1 == m_resp_at) begin
          m_rd[m_owner] = m_res_data; m_er[m_owner] = m_res_err;
        end
        m_age++;
      end
    end
  end

  task automatic issue_req(input logic who, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output int t_gnt);
    @(posedge clk); #1;
    if (!who) begin ifu_req = 1'b1; ifu_we = we; ifu_addr = addr; ifu_wdata = wd; end
    else      begin dfu_req = 1'b1; dfu_we = we; dfu_addr = addr; dfu_wdata = wd; end
    t_gnt = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((!who && ifu_gnt) || (who && dfu_gnt)) begin t_gnt = cyc; break; end
    end
    check("gnt_seen", 64'(t_gnt >= 0), 64'd1);
    @(posedge clk); #1;
    if (!who) ifu_req = 1'b0; else dfu_req = 1'b0;
  endtask

  task automatic wait_resp(input logic who, output int t_resp);
    t_resp = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((!who && ifu_resp_valid) || (who && dfu_resp_valid)) begin t_resp = cyc; break; end
    end
    check("resp_seen", 64'(t_resp >= 0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int tg, tr, ni, nd;
  int order[$];

  initial begin
    rstn = 1'b0;
    ifu_req = 1'b0; ifu_we = 1'b0; ifu_addr = '0; ifu_wdata = '0;
    dfu_req = 1'b0; dfu_we = 1'b0; dfu_addr = '0; dfu_wdata = '0;
    cu2ar_data_out = 64'hDEAD_BEEF_0000_1234;
    cu2ar_busy = 1'b0; cu2ar_start_wl = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1; cu2ar_start_wl = 1'b1;

    // IFU write: issue next cycle, response two cycles after grant
    issue_req(1'b0, 1'b1, ADDR_DMA_SIZE, 64'h0000_0040_0000_0100, tg);
    @(negedge clk);
    check("wr_issue_strobe", 64'(ar2cu_wr_rqst && ar2cu_addr_valid && ar2cu_data_in_valid), 64'd1);
    check("wr_issue_addr", 64'(ar2cu_addr), 64'h403);
    check("wr_issue_data", ar2cu_data_in, 64'h0000_0040_0000_0100);
    wait_resp(1'b0, tr);
    check("wr_latency", 64'(tr - tg), 64'd2);
    check("wr_err", 64'(ifu_err), 64'd0);

    // DFU read answered by the stub: three cycles grant to response
    stub_on = 1'b1;
    issue_req(1'b1, 1'b0, ADDR_DFU_2, '0, tg);
    wait_resp(1'b1, tr);
    check("rd_latency", 64'(tr - tg), 64'd3);
    check("rd_data", dfu_rdata, 64'hDEAD_BEEF_0000_1234);
    check("rd_err", 64'(dfu_err), 64'd0);

    // Both requesting continuously: grants alternate starting with IFU
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_we = 1'b0; ifu_addr = ADDR_PROG_SIZE;
    dfu_req = 1'b1; dfu_we = 1'b0; dfu_addr = ADDR_DFU_3;
    ni = 0; nd = 0;
    for (int i = 0; i < 100 && order.size() < 8; i++) begin
      @(negedge clk);
      if (ifu_gnt) begin order.push_back(0); ni++; end
      if (dfu_gnt) begin order.push_back(1); nd++; end
      @(posedge clk); #1;
      if (ni == 4) ifu_req = 1'b0;
      if (nd == 4) dfu_req = 1'b0;
    end
    ifu_req = 1'b0; dfu_req = 1'b0;
    check("alt_count", 64'(order.size()), 64'd8);
    foreach (order[i]) check("alt_order", 64'(order[i]), 64'(i % 2));
    repeat (6) @(posedge clk);

    // Busy blocks grants; grant in the first non-busy cycle
    #1 cu2ar_busy = 1'b1; ifu_req = 1'b1; ifu_we = 1'b0; ifu_addr = ADDR_PROG_START;
    repeat (5) begin
      @(negedge clk); check("busy_no_gnt", 64'(ifu_gnt), 64'd0);
      @(posedge clk); #1;
    end
    cu2ar_busy = 1'b0;
    @(negedge clk); check("busy_release_gnt", 64'(ifu_gnt), 64'd1);
    @(posedge clk); #1 ifu_req = 1'b0;
    repeat (6) @(posedge clk);

    // Workload not started blocks grants the same way
    #1 cu2ar_start_wl = 1'b0; dfu_req = 1'b1; dfu_we = 1'b0; dfu_addr = ADDR_DFU_3;
    repeat (3) begin
      @(negedge clk); check("startwl_no_gnt", 64'(dfu_gnt), 64'd0);
      @(posedge clk); #1;
    end
    cu2ar_start_wl = 1'b1;
    @(negedge clk); check("startwl_gnt", 64'(dfu_gnt), 64'd1);
    @(posedge clk); #1 dfu_req = 1'b0;
    repeat (6) @(posedge clk);

    // Read timeout: response at grant+RT+2 with error
    stub_on = 1'b0;
    issue_req(1'b0, 1'b0, ADDR_DMA_SRC, '0, tg);
    wait_resp(1'b0, tr);
    check("to_latency", 64'(tr - tg), 64'd17);
    check("to_err", 64'(ifu_err), 64'd1);
    check("to_rdata", ifu_rdata, 64'd0);
    check("errcnt_first", 64'(arb_err_cnt), 64'd1);
    for (int k = 0; k < 255; k++) begin
      issue_req(k[0], 1'b0, ADDR_DMA_SRC, '0, tg);
      wait_resp(k[0], tr);
    end
    check("errcnt_sat", 64'(arb_err_cnt), 64'd255);

    // Reset while a read waits: outputs clear at once, no late response
    issue_req(1'b0, 1'b0, ADDR_DMA_DST, '0, tg);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_rd_rqst", 64'(ar2cu_rd_rqst || ar2cu_addr_valid), 64'd0);
    check("rst_errcnt", 64'(arb_err_cnt), 64'd0);
    check("rst_ifu_err", 64'(ifu_err), 64'd0);
    check("rst_ar2cu_addr", 64'(ar2cu_addr), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("rst_no_resp", 64'(ifu_resp_valid || dfu_resp_valid), 64'd0);
    end
    stub_on = 1'b1;
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_we = 1'b0; dfu_req = 1'b1; dfu_we = 1'b0;
    @(negedge clk);
    check("rst_ifu_first", 64'({ifu_gnt, dfu_gnt}), 64'b10);
    @(posedge clk); #1 ifu_req = 1'b0; dfu_req = 1'b0;
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
